bram_sp_clr: RTL and testbench

//  Parametrised single-port synchronous block RAM, next generation of the 16x8 lab RAM.

---
 rtl/bram_sp_clr.sv | 65 ++++++
 tb/tb_bram_sp_clr.sv | 102 ++++++++++
 2 files changed

// File: rtl/bram_sp_clr.sv
// bram_sp_clr: single-port BRAM with selectable read-during-write mode and a clear pass after every reset.
// Defining BRAM_OUT_REG_EN adds an output register, giving a read latency of 2.
module bram_sp_clr #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int READ_MODE = 0,
   parameter logic [DATA_WIDTH-1:0] CLR_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  busy
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {CLEAR, READY} state_t;
   state_t state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic vld_q;
   logic acc;
   assign acc = en && !busy;
   always_ff @(posedge clk) begin
      if (!rst && busy) mem[cnt] <= CLR_VAL;
      else if (!rst && acc && we) mem[addr] <= din;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt <= '0;
         busy <= 1'b1;
         rd_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= acc && !(we && READ_MODE == 2);
         if (acc) rd_q <= !we ? mem[addr] : READ_MODE == 1 ? din : READ_MODE == 2 ? rd_q : mem[addr];
         if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
               state <= READY;
               busy <= 1'b0;
            end
         end
      end
   end
`ifdef BRAM_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout <= rd_q;
         dout_vld <= vld_q;
      end
   end
`else
   assign dout = rd_q;
   assign dout_vld = vld_q;
`endif
endmodule

// File: tb/tb_bram_sp_clr.sv
// tb_bram_sp_clr: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST with CLR_VAL=0xA5)
// driven in lockstep and compared every cycle against an array-based model.
module tb_bram_sp_clr;
   logic clk = 1'b0;
   logic rst, en, we;
   logic [3:0] addr;
   logic [7:0] din;
   logic [7:0] dout [4];
   logic vld [4];
   logic busy [4];
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   bram_sp_clr #(.READ_MODE(0)) u_rf (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout[0]), .dout_vld(vld[0]), .busy(busy[0]));
   bram_sp_clr #(.READ_MODE(1)) u_wf (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout[1]), .dout_vld(vld[1]), .busy(busy[1]));
   bram_sp_clr #(.READ_MODE(2)) u_nc (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout[2]), .dout_vld(vld[2]), .busy(busy[2]));
   bram_sp_clr #(.READ_MODE(0), .CLR_VAL(8'hA5)) u_a5 (.clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din), .dout(dout[3]), .dout_vld(vld[3]), .busy(busy[3]));
   int md [4] = '{0, 1, 2, 0};
   logic [7:0] clr [4] = '{8'h00, 8'h00, 8'h00, 8'hA5};
   logic [7:0] m [4][16];
   int left [4];
   logic [7:0] ed [4], pd [4];
   logic ev [4], pv [4];
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input logic r, input logic e, input logic w, input logic [3:0] a, input logic [7:0] d);
      logic [7:0] old;
      rst = r; en = e; we = w; addr = a; din = d;
      for (int k = 0; k < 4; k++) begin
         pd[k] = r ? 8'h00 : ed[k];
         pv[k] = r ? 1'b0 : ev[k];
         if (r) begin
            left[k] = 16;
            for (int j = 0; j < 16; j++) m[k][j] = clr[k];
            ed[k] = 8'h00;
            ev[k] = 1'b0;
         end else if (left[k] != 0) begin
            left[k]--;
            ev[k] = 1'b0;
         end else if (e && w) begin
            old = m[k][a];
            m[k][a] = d;
            ed[k] = md[k] == 0 ? old : md[k] == 1 ? d : ed[k];
            ev[k] = md[k] != 2;
         end else if (e) begin
            ed[k] = m[k][a];
            ev[k] = 1'b1;
         end else ev[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("busy%0d", k), {7'b0, busy[k]}, {7'b0, left[k] != 0});
`ifdef BRAM_OUT_REG_EN
         chk($sformatf("dout%0d", k), dout[k], pd[k]);
         chk($sformatf("vld%0d", k), {7'b0, vld[k]}, {7'b0, pv[k]});
`else
         chk($sformatf("dout%0d", k), dout[k], ed[k]);
         chk($sformatf("vld%0d", k), {7'b0, vld[k]}, {7'b0, ev[k]});
`endif
      end
   endtask
   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
      step(1, 0, 0, 0, 0);
      repeat (16) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(i), 0);
      step(0, 1, 1, 0, 8'h17);
      step(0, 1, 1, 1, 8'h2D);
      step(0, 1, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      step(0, 1, 1, 15, 8'h59);
      step(0, 0, 1, 14, 8'h00);
      step(0, 1, 0, 14, 0);
      step(0, 1, 0, 15, 0);
      step(0, 1, 1, 0, 8'h38);
      step(0, 1, 1, 0, 8'h01);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (7) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0);
      step(0, 1, 1, 3, 8'h4E);
      repeat (10) step(0, 1, 0, 3, 0);
      step(0, 1, 0, 3, 0);
      step(0, 1, 1, 5, 8'h77);
      step(0, 1, 1, 9, 8'h3C);
      step(1, 0, 0, 0, 0);
      repeat (16) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(i), 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), 8'($urandom));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
